// File: rtl/scalar_mult_ctrl_if.sv
// Host and point-unit signal bundle for the scalar multiplication controller.
// slave = controller view, master = host / point-unit view.
interface scalar_mult_ctrl_if #(
    parameter int W  = 4,
    parameter int KW = 4
);
    logic          start;
    logic [KW-1:0] k;
    logic [W-1:0]  px;
    logic [W-1:0]  py;
    logic          busy;
    logic          done;
    logic [W-1:0]  qx;
    logic [W-1:0]  qy;
    logic          q_inf;
    logic          pu_req;
    logic          pu_op;
    logic [W-1:0]  pu_x1;
    logic [W-1:0]  pu_y1;
    logic [W-1:0]  pu_x2;
    logic [W-1:0]  pu_y2;
    logic          pu_ack;
    logic [W-1:0]  pu_rx;
    logic [W-1:0]  pu_ry;

    modport slave (
        input  start, k, px, py, pu_ack, pu_rx, pu_ry,
        output busy, done, qx, qy, q_inf,
               pu_req, pu_op, pu_x1, pu_y1, pu_x2, pu_y2
    );

    modport master (
        output start, k, px, py, pu_ack, pu_rx, pu_ry,
        input  busy, done, qx, qy, q_inf,
               pu_req, pu_op, pu_x1, pu_y1, pu_x2, pu_y2
    );
endinterface

// File: rtl/scalar_mult_ctrl.sv
// LSB-first double-and-add controller for k*P over GF(2^W); point arithmetic
// is delegated to a shared point unit through a req/ack handshake.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | evaluate scalar bit idx
// ADD   | Q := Q + R (local shortcut or point-unit op)
// DBL   | R := 2R (local shortcut or point-unit op), then advance idx
// FIN   | publish result, pulse done
module scalar_mult_ctrl #(
    parameter int W  = 4,
    parameter int KW = 4
) (
    input  logic              clock,
    input  logic              reset,
    scalar_mult_ctrl_if.slave bus
);
    localparam int IW = (KW > 1) ? $clog2(KW) : 1;

    typedef enum logic [2:0] {IDLE, SCAN, ADD, DBL, FIN} state_t;

    state_t        state;
    logic [KW-1:0] k_r;
    logic [IW-1:0] idx;
    logic [W-1:0]  qx_r, qy_r, rx_r, ry_r;
    logic          qi_r, ri_r;

    logic [KW-1:0] k_sh;
    logic          bit_i;
    logic          hi_rem;

    always_comb begin
        k_sh   = k_r >> idx;
        bit_i  = k_sh[0];
        hi_rem = |(k_sh >> 1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            k_r        <= '0;
            idx        <= '0;
            qx_r       <= '0;
            qy_r       <= '0;
            rx_r       <= '0;
            ry_r       <= '0;
            qi_r       <= 1'b1;
            ri_r       <= 1'b1;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.qx     <= '0;
            bus.qy     <= '0;
            bus.q_inf  <= 1'b1;
            bus.pu_req <= 1'b0;
            bus.pu_op  <= 1'b0;
            bus.pu_x1  <= '0;
            bus.pu_y1  <= '0;
            bus.pu_x2  <= '0;
            bus.pu_y2  <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        k_r      <= bus.k;
                        rx_r     <= bus.px;
                        ry_r     <= bus.py;
                        ri_r     <= 1'b0;
                        qx_r     <= '0;
                        qy_r     <= '0;
                        qi_r     <= 1'b1;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (bit_i)       state <= ADD;
                    else if (hi_rem) state <= DBL;
                    else             state <= FIN;
                end
                ADD: begin
                    if (bus.pu_req) begin
                        if (bus.pu_ack) begin
                            qx_r       <= bus.pu_rx;
                            qy_r       <= bus.pu_ry;
                            qi_r       <= 1'b0;
                            bus.pu_req <= 1'b0;
                            state      <= hi_rem ? DBL : FIN;
                        end
                    end else if (qi_r) begin
                        qx_r  <= rx_r;
                        qy_r  <= ry_r;
                        qi_r  <= ri_r;
                        state <= hi_rem ? DBL : FIN;
                    end else if (ri_r) begin
                        state <= hi_rem ? DBL : FIN;
                    end else if (qx_r == rx_r && qy_r != ry_r) begin
                        // R is -Q in characteristic 2, so the sum is the point at infinity
                        qx_r  <= '0;
                        qy_r  <= '0;
                        qi_r  <= 1'b1;
                        state <= hi_rem ? DBL : FIN;
                    end else begin
                        // qx == rx here implies Q == R, which the unit must double instead
                        bus.pu_req <= 1'b1;
                        bus.pu_op  <= (qx_r != rx_r);
                        bus.pu_x1  <= qx_r;
                        bus.pu_y1  <= qy_r;
                        bus.pu_x2  <= rx_r;
                        bus.pu_y2  <= ry_r;
                    end
                end
                DBL: begin
                    if (bus.pu_req) begin
                        if (bus.pu_ack) begin
                            rx_r       <= bus.pu_rx;
                            ry_r       <= bus.pu_ry;
                            ri_r       <= 1'b0;
                            bus.pu_req <= 1'b0;
                            idx        <= idx + 1'b1;
                            state      <= SCAN;
                        end
                    end else if (ri_r || rx_r == '0) begin
                        rx_r  <= '0;
                        ry_r  <= '0;
                        ri_r  <= 1'b1;
                        idx   <= idx + 1'b1;
                        state <= SCAN;
                    end else begin
                        bus.pu_req <= 1'b1;
                        bus.pu_op  <= 1'b0;
                        bus.pu_x1  <= rx_r;
                        bus.pu_y1  <= ry_r;
                        bus.pu_x2  <= '0;
                        bus.pu_y2  <= '0;
                    end
                end
                FIN: begin
                    bus.done  <= 1'b1;
                    bus.busy  <= 1'b0;
                    bus.qx    <= qi_r ? '0 : qx_r;
                    bus.qy    <= qi_r ? '0 : qy_r;
                    bus.q_inf <= qi_r;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Directed bench for scalar_mult_ctrl with a toy point unit:
// double(x,y) = (x+3, y+5), add(x1,y1,x2,y2) = (x1+x2, y1+y2+1), all mod 16.
module tb_scalar_mult_ctrl;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    scalar_mult_ctrl_if #(.W(4), .KW(4)) bus ();
    scalar_mult_ctrl #(.W(4), .KW(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    int checks = 0;
    int passed = 0;

    int       n_req;
    logic     log_op [0:15];
    logic [3:0] log_x1 [0:15];
    logic [3:0] log_y1 [0:15];
    logic [3:0] log_x2 [0:15];
    logic [3:0] log_y2 [0:15];
    int       stab_bad;
    bit       model_en = 1'b1;
    bit       rand_delay = 1'b0;
    int       fixed_delay = 2;
    logic     manual_ack = 1'b0;
    logic [3:0] manual_rx = 4'h0;
    logic [3:0] manual_ry = 4'h0;
    int       done_cnt;

    logic       lat_op;
    logic [3:0] lat_x1, lat_y1, lat_x2, lat_y2;
    int         cnt = 0;
    int         dly = 1;

    initial begin
        bus.pu_ack = 1'b0;
        bus.pu_rx  = 4'h0;
        bus.pu_ry  = 4'h0;
        forever begin
            @(negedge clock);
            if (!model_en) begin
                bus.pu_ack = manual_ack;
                bus.pu_rx  = manual_rx;
                bus.pu_ry  = manual_ry;
                cnt = 0;
            end else begin
                bus.pu_ack = 1'b0;
                if (bus.pu_req === 1'b1) begin
                    if (cnt == 0) begin
                        lat_op = bus.pu_op;
                        lat_x1 = bus.pu_x1; lat_y1 = bus.pu_y1;
                        lat_x2 = bus.pu_x2; lat_y2 = bus.pu_y2;
                        if (n_req < 16) begin
                            log_op[n_req] = lat_op;
                            log_x1[n_req] = lat_x1; log_y1[n_req] = lat_y1;
                            log_x2[n_req] = lat_x2; log_y2[n_req] = lat_y2;
                        end
                        n_req++;
                        dly = rand_delay ? int'($urandom_range(1, 5)) : fixed_delay;
                    end else if (bus.pu_op !== lat_op || bus.pu_x1 !== lat_x1 || bus.pu_y1 !== lat_y1 ||
                                 bus.pu_x2 !== lat_x2 || bus.pu_y2 !== lat_y2) begin
                        stab_bad++;
                    end
                    cnt++;
                    if (cnt >= dly) begin
                        bus.pu_ack = 1'b1;
                        if (lat_op) begin
                            bus.pu_rx = lat_x1 + lat_x2;
                            bus.pu_ry = lat_y1 + lat_y2 + 4'd1;
                        end else begin
                            bus.pu_rx = lat_x1 + 4'd3;
                            bus.pu_ry = lat_y1 + 4'd5;
                        end
                        cnt = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        done_cnt = 0;
        forever begin
            @(negedge clock);
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic start_op(input logic [3:0] kk, input logic [3:0] px_v, input logic [3:0] py_v);
        @(negedge clock);
        bus.start = 1'b1; bus.k = kk; bus.px = px_v; bus.py = py_v;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the accepting edge; inj > 0 pulses start with k=0 in that cycle.
    task automatic wait_done(input int max_c, input int inj, output int cyc);
        cyc = -1;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clock);
            if (c == inj) begin
                bus.start = 1'b1; bus.k = 4'h0; bus.px = 4'h0; bus.py = 4'h0;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                cyc = c;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1; bus.k = 4'h1; bus.px = 4'hF; bus.py = 4'hF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
        checks++; if (bus.pu_req !== 1'b0) $display("FAIL reset_pu_req: got %b want 0", bus.pu_req); else passed++;
        checks++; if (bus.q_inf !== 1'b1) $display("FAIL reset_q_inf: got %b want 1", bus.q_inf); else passed++;
        checks++; if ({bus.qx, bus.qy} !== 8'h00) $display("FAIL reset_q: got %h%h want 00", bus.qx, bus.qy); else passed++;
        checks++;
        if ({bus.pu_op, bus.pu_x1, bus.pu_y1, bus.pu_x2, bus.pu_y2} !== 17'h0)
            $display("FAIL reset_operands: got op=%b %h %h %h %h want all 0", bus.pu_op, bus.pu_x1, bus.pu_y1, bus.pu_x2, bus.pu_y2);
        else passed++;
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clock);
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_priority_busy: got %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_k0();
        int cyc;
        n_req = 0;
        start_op(4'h0, 4'hF, 4'hF);
        checks++; if (bus.busy !== 1'b1) $display("FAIL k0_busy_after_accept: got %b want 1", bus.busy); else passed++;
        wait_done(20, 0, cyc);
        checks++; if (cyc !== 3) $display("FAIL k0_latency: got %0d want 3", cyc); else passed++;
        checks++; if (bus.q_inf !== 1'b1) $display("FAIL k0_q_inf: got %b want 1", bus.q_inf); else passed++;
        checks++; if ({bus.qx, bus.qy} !== 8'h00) $display("FAIL k0_q: got %h%h want 00", bus.qx, bus.qy); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL k0_busy_at_done: got %b want 0", bus.busy); else passed++;
        checks++; if (n_req !== 0) $display("FAIL k0_requests: got %0d want 0", n_req); else passed++;
        @(negedge clock);
        checks++; if (bus.done !== 1'b0) $display("FAIL k0_done_pulse_width: got %b want 0", bus.done); else passed++;
    endtask

    task automatic test_k1();
        int cyc;
        n_req = 0;
        start_op(4'h1, 4'hF, 4'hF);
        wait_done(20, 0, cyc);
        checks++; if (cyc !== 4) $display("FAIL k1_latency: got %0d want 4", cyc); else passed++;
        checks++; if (n_req !== 0) $display("FAIL k1_requests: got %0d want 0", n_req); else passed++;
        checks++; if ({bus.qx, bus.qy, bus.q_inf} !== {8'hFF, 1'b0})
            $display("FAIL k1_result: got (%h,%h) inf=%b want (f,f) inf=0", bus.qx, bus.qy, bus.q_inf); else passed++;
    endtask

    task automatic test_local_double();
        int cyc;
        n_req = 0;
        start_op(4'h2, 4'h0, 4'h1);
        wait_done(20, 0, cyc);
        checks++; if (cyc !== 6) $display("FAIL k2_latency: got %0d want 6", cyc); else passed++;
        checks++; if (n_req !== 0) $display("FAIL k2_requests: got %0d want 0", n_req); else passed++;
        checks++; if ({bus.qx, bus.qy, bus.q_inf} !== {8'h00, 1'b1})
            $display("FAIL k2_result: got (%h,%h) inf=%b want (0,0) inf=1", bus.qx, bus.qy, bus.q_inf); else passed++;
    endtask

    task automatic test_k3_ignore_start();
        int cyc;
        n_req = 0; stab_bad = 0; rand_delay = 1'b0; fixed_delay = 2;
        start_op(4'h3, 4'hF, 4'hF);
        wait_done(60, 4, cyc);
        checks++; if (cyc !== 11) $display("FAIL k3_latency: got %0d want 11", cyc); else passed++;
        checks++; if (n_req !== 2) $display("FAIL k3_requests: got %0d want 2", n_req); else passed++;
        checks++; if ({log_op[0], log_x1[0], log_y1[0]} !== {1'b0, 8'hFF})
            $display("FAIL k3_req0: got op=%b (%h,%h) want op=0 (f,f)", log_op[0], log_x1[0], log_y1[0]); else passed++;
        checks++; if ({log_op[1], log_x1[1], log_y1[1], log_x2[1], log_y2[1]} !== {1'b1, 16'hFF24})
            $display("FAIL k3_req1: got op=%b (%h,%h)(%h,%h) want op=1 (f,f)(2,4)",
                     log_op[1], log_x1[1], log_y1[1], log_x2[1], log_y2[1]); else passed++;
        checks++; if ({bus.qx, bus.qy, bus.q_inf} !== {8'h14, 1'b0})
            $display("FAIL k3_result: got (%h,%h) inf=%b want (1,4) inf=0", bus.qx, bus.qy, bus.q_inf); else passed++;
        checks++; if (stab_bad !== 0) $display("FAIL k3_operand_stability: got %0d changes want 0", stab_bad); else passed++;
    endtask

    task automatic test_k15_random();
        int cyc;
        logic       e_op [0:5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] e_x1 [0:5] = '{4'hF, 4'hF, 4'h2, 4'h1, 4'h5, 4'h6};
        logic [3:0] e_y1 [0:5] = '{4'hF, 4'hF, 4'h4, 4'h4, 4'h9, 4'hE};
        logic [3:0] e_x2 [0:5] = '{4'h0, 4'h2, 4'h0, 4'h5, 4'h0, 4'h8};
        logic [3:0] e_y2 [0:5] = '{4'h0, 4'h4, 4'h0, 4'h9, 4'h0, 4'hE};
        int bad_seq;
        n_req = 0; stab_bad = 0; rand_delay = 1'b1;
        start_op(4'hF, 4'hF, 4'hF);
        wait_done(200, 0, cyc);
        rand_delay = 1'b0;
        checks++; if (cyc < 0) $display("FAIL k15_timeout: got no done want done within 200 cycles"); else passed++;
        checks++; if (n_req !== 6) $display("FAIL k15_requests: got %0d want 6", n_req); else passed++;
        bad_seq = 0;
        for (int i = 0; i < 6; i++) begin
            if (log_op[i] !== e_op[i] || log_x1[i] !== e_x1[i] || log_y1[i] !== e_y1[i] ||
                (e_op[i] && (log_x2[i] !== e_x2[i] || log_y2[i] !== e_y2[i]))) begin
                bad_seq++;
                $display("FAIL k15_req%0d: got op=%b (%h,%h)(%h,%h) want op=%b (%h,%h)(%h,%h)", i,
                         log_op[i], log_x1[i], log_y1[i], log_x2[i], log_y2[i],
                         e_op[i], e_x1[i], e_y1[i], e_x2[i], e_y2[i]);
            end
        end
        checks++; if (bad_seq == 0) passed++;
        checks++; if (stab_bad !== 0) $display("FAIL k15_operand_stability: got %0d changes want 0", stab_bad); else passed++;
        checks++; if ({bus.qx, bus.qy, bus.q_inf} !== {8'hED, 1'b0})
            $display("FAIL k15_result: got (%h,%h) inf=%b want (e,d) inf=0", bus.qx, bus.qy, bus.q_inf); else passed++;
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        bit seen;
        model_en = 1'b0; manual_ack = 1'b0; done_cnt = 0;
        start_op(4'h3, 4'hF, 4'hF);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.pu_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) $display("FAIL rst_mid_req_seen: got no pu_req want pu_req high"); else passed++;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        manual_ack = 1'b1; manual_rx = 4'h7; manual_ry = 4'h7;
        @(negedge clock);
        @(negedge clock);
        manual_ack = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (done_cnt !== 0) $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt); else passed++;
        checks++; if ({bus.busy, bus.pu_req, bus.q_inf} !== 3'b001)
            $display("FAIL rst_mid_flags: got busy=%b req=%b inf=%b want 0 0 1", bus.busy, bus.pu_req, bus.q_inf); else passed++;
        checks++; if ({bus.qx, bus.qy, bus.pu_x1, bus.pu_y1} !== 16'h0000)
            $display("FAIL rst_mid_values: got q=(%h,%h) x1=%h y1=%h want zeros", bus.qx, bus.qy, bus.pu_x1, bus.pu_y1); else passed++;
        model_en = 1'b1;
        n_req = 0;
        start_op(4'h1, 4'h3, 4'h5);
        wait_done(20, 0, cyc);
        checks++; if (cyc !== 4) $display("FAIL rst_mid_restart_latency: got %0d want 4", cyc); else passed++;
        checks++; if ({bus.qx, bus.qy, bus.q_inf} !== {8'h35, 1'b0})
            $display("FAIL rst_mid_restart_result: got (%h,%h) inf=%b want (3,5) inf=0", bus.qx, bus.qy, bus.q_inf); else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        repeat (3) @(negedge clock);
        checks++; if ({bus.qx, bus.qy, bus.q_inf} !== {8'h35, 1'b0})
            $display("FAIL b2b_hold: got (%h,%h) inf=%b want (3,5) inf=0", bus.qx, bus.qy, bus.q_inf); else passed++;
        start_op(4'h0, 4'h1, 4'h1);
        checks++; if ({bus.qx, bus.qy} !== 8'h35)
            $display("FAIL b2b_hold_until_fin: got (%h,%h) want (3,5)", bus.qx, bus.qy); else passed++;
        wait_done(20, 0, cyc);
        checks++; if ({cyc, bus.q_inf, bus.qx, bus.qy} !== {32'd3, 1'b1, 8'h00})
            $display("FAIL b2b_k0: got cyc=%0d inf=%b (%h,%h) want cyc=3 inf=1 (0,0)", cyc, bus.q_inf, bus.qx, bus.qy); else passed++;
        start_op(4'h1, 4'hA, 4'h6);
        wait_done(20, 0, cyc);
        checks++; if ({bus.qx, bus.qy, bus.q_inf} !== {8'hA6, 1'b0})
            $display("FAIL b2b_k1: got (%h,%h) inf=%b want (a,6) inf=0", bus.qx, bus.qy, bus.q_inf); else passed++;
    endtask

    initial begin
        bus.start = 1'b0; bus.k = 4'h0; bus.px = 4'h0; bus.py = 4'h0;
        n_req = 0; stab_bad = 0;
        test_reset();
        test_k0();
        test_k1();
        test_local_double();
        test_k3_ignore_start();
        test_k15_random();
        test_reset_mid_op();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
